display_scan_controller: RTL

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

---
 rtl/display_scan_controller.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Time-multiplexed scan of four 4-bit digit codes onto a downstream
//   2-to-4 decoder with enable. Each digit is shown for DWELL cycles,
//   optionally followed by GAP blanking cycles, and frame_done pulses
//   once every time the scan wraps from digit 3 back to digit 0.
//
//   Parameters
//     DWELL  cycles each digit is driven per visit (1..255)
//     GAP    blanking cycles between consecutive digits (0..15)
//
//   Ports
//     clk         rising-edge clock
//     rst         asynchronous active-high reset
//     run         scan enable; a low sample stops the scan immediately
//     data[15:0]  four digit codes, digit i = data[4i+3:4i]
//     mask[3:0]   per-digit blank; bit i suppresses enable for digit i
//     sel[1:0]    index of the digit currently on the decoder
//     enable      decoder enable
//     digit[3:0]  code of the currently selected digit
//     frame_done  one-cycle pulse at the 3 -> 0 index wrap
//
//   All outputs are registered; data and mask are only sampled at the
//   edge that starts a digit visit.
module display_scan_controller #(
  parameter int DWELL = 8,
  parameter int GAP   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] data,
  input  logic [3:0]  mask,
  output logic [1:0]  sel,
  output logic        enable,
  output logic [3:0]  digit,
  output logic        frame_done
);

  // One counter serves both the dwell and the gap phases. It only ever
  // reaches (phase length - 1), so $clog2 of the longer phase is enough.
  localparam int MAXV = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [1:0]    index, index_n;
  logic [CW-1:0] count, count_n;
  logic [1:0]    sel_n;
  logic          enable_n;
  logic [3:0]    digit_n;
  logic          frame_done_n;

  // Helpers for the two shared actions: starting a digit visit, and
  // dropping back to IDLE when run goes low.
  logic          load;
  logic [1:0]    load_idx;
  logic          go_idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      index      <= 2'd0;
      count      <= '0;
      sel        <= 2'd0;
      enable     <= 1'b0;
      digit      <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      index      <= index_n;
      count      <= count_n;
      sel        <= sel_n;
      enable     <= enable_n;
      digit      <= digit_n;
      frame_done <= frame_done_n;
    end
  end

  always_comb begin
    state_n      = state;
    index_n      = index;
    count_n      = count;
    sel_n        = sel;
    enable_n     = enable;
    digit_n      = digit;
    frame_done_n = 1'b0;
    load         = 1'b0;
    load_idx     = index;
    go_idle      = 1'b0;

    case (state)
      IDLE: begin
        sel_n    = 2'd0;
        enable_n = 1'b0;
        index_n  = 2'd0;
        count_n  = '0;
        if (run) begin
          load     = 1'b1;
          load_idx = 2'd0;
        end
      end

      SHOW: begin
        if (!run) begin
          go_idle = 1'b1;
        end else if (count == DWELL_LAST) begin
          if (GAP > 0) begin
            state_n  = BLANK;
            enable_n = 1'b0;
            count_n  = '0;
          end else begin
            // No blanking: step straight to the next digit.
            load         = 1'b1;
            load_idx     = index + 2'd1;
            frame_done_n = (index == 2'd3);
          end
        end else begin
          count_n = count + 1'b1;
        end
      end

      BLANK: begin
        if (!run) begin
          go_idle = 1'b1;
        end else if (count == GAP_LAST) begin
          load         = 1'b1;
          load_idx     = index + 2'd1;
          frame_done_n = (index == 2'd3);
        end else begin
          count_n = count + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // Start of a visit: latch the digit code and its mask bit so that
    // later changes on data/mask cannot disturb the visit in progress.
    if (load) begin
      state_n  = SHOW;
      index_n  = load_idx;
      count_n  = '0;
      sel_n    = load_idx;
      digit_n  = data[4*load_idx +: 4];
      enable_n = ~mask[load_idx];
    end

    // A stop abandons the partial frame; digit keeps its last code.
    if (go_idle) begin
      state_n      = IDLE;
      index_n      = 2'd0;
      count_n      = '0;
      sel_n        = 2'd0;
      enable_n     = 1'b0;
      frame_done_n = 1'b0;
    end
  end

endmodule
